// File: rtl/dl_pkg.sv
// Shared types for the ROM download sequencer: sequencer and drain state encodings
// plus the default ioctl stream indices.
package dl_pkg;

  typedef enum logic [1:0] {SeqIdle, SeqLoad, SeqHold, SeqRun} seq_state_e;

  typedef enum logic {DrnIdle, DrnWr} drain_state_e;

  localparam logic [7:0] BramIndexDefault  = 8'd0;
  localparam logic [7:0] ModeIndexDefault  = 8'd1;
  localparam logic [7:0] SdramIndexDefault = 8'd2;

endpackage

// File: rtl/rom_download_sequencer_if.sv
// HPS ioctl byte stream and SDRAM write port bundled as one interface.
// The slave modport is the sequencer's view; master is the HPS/SDRAM side.
interface rom_download_sequencer_if #(
  parameter int unsigned ADDR_W       = 24,
  parameter int unsigned SDRAM_ADDR_W = 25
);

  logic                    ioctl_download;
  logic                    ioctl_wr;
  logic [7:0]              ioctl_index;
  logic [ADDR_W-1:0]       ioctl_addr;
  logic [7:0]              ioctl_dout;
  logic                    ioctl_wait;
  logic [SDRAM_ADDR_W-1:0] sdram_addr;
  logic [7:0]              sdram_din;
  logic                    sdram_wr;
  logic                    sdram_ack;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout, sdram_ack,
    input  ioctl_wait, sdram_addr, sdram_din, sdram_wr
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout, sdram_ack,
    output ioctl_wait, sdram_addr, sdram_din, sdram_wr
  );

endinterface

// File: rtl/dl_sync_fifo.sv
// Small synchronous FIFO; exposes the head and the entry behind it so the drain
// side can reload its output registers on the same edge it pops.
module dl_sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clk_sys,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           head,
  output logic [WIDTH-1:0]           head_next,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_ok, pop_ok;

  assign full      = (count_q == CntW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign pop_ok    = pop & ~empty;
  // A push into a full FIFO still fits when the head leaves on the same edge.
  assign push_ok   = push & (~full | pop_ok);
  assign head      = mem_q[rd_ptr_q];
  assign head_next = mem_q[rd_ptr_q + PtrW'(1)];

  always_ff @(posedge clk_sys) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push_ok && !pop_ok)      count_q <= count_q + CntW'(1);
      else if (!push_ok && pop_ok) count_q <= count_q - CntW'(1);
    end
  end

endmodule

// File: rtl/rom_download_sequencer.sv
// Buffers SDRAM-bound ioctl bytes, drains them under req/ack, latches game_mode and
// holds the game core in reset until a ROM has loaded, drained and aged HOLD_CYCLES.
module rom_download_sequencer
  import dl_pkg::*;
#(
  parameter int unsigned ADDR_W       = 24,
  parameter int unsigned SDRAM_ADDR_W = 25,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned HOLD_CYCLES  = 255,
  parameter logic [7:0]  BRAM_INDEX   = BramIndexDefault,
  parameter logic [7:0]  MODE_INDEX   = ModeIndexDefault,
  parameter logic [7:0]  SDRAM_INDEX  = SdramIndexDefault
) (
  input  logic                           clk_sys,
  input  logic                           reset_n,
  rom_download_sequencer_if.slave        dl_bus,
  output logic [4:0]                     game_mode,
  output logic                           core_reset,
  output logic                           rom_loaded,
  output logic                           fifo_overflow
);

  localparam int unsigned EntryW   = ADDR_W + 8;
  localparam int unsigned FifoCntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned HoldCntW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

  seq_state_e            seq_q;
  drain_state_e          drain_q;
  logic [HoldCntW-1:0]   hold_cnt_q;
  logic                  core_reset_q, rom_loaded_q, overflow_q, wait_q;
  logic [4:0]            game_mode_q;
  logic [SDRAM_ADDR_W-1:0] sdram_addr_q;
  logic [7:0]            sdram_din_q;
  logic                  sdram_wr_q;

  logic                  rom_dl, push, pop, push_ok;
  logic                  fifo_full, fifo_empty;
  logic [FifoCntW-1:0]   fifo_count, count_nxt;
  logic [EntryW-1:0]     push_entry, fifo_head, fifo_head_next, load_entry;
  logic                  drain_load;

  assign rom_dl = dl_bus.ioctl_download &
                  ((dl_bus.ioctl_index == BRAM_INDEX) | (dl_bus.ioctl_index == SDRAM_INDEX));
  assign push       = dl_bus.ioctl_download & dl_bus.ioctl_wr & (dl_bus.ioctl_index == SDRAM_INDEX);
  assign pop        = (drain_q == DrnWr) & dl_bus.sdram_ack;
  assign push_ok    = push & (~fifo_full | pop);
  assign push_entry = {dl_bus.ioctl_addr, dl_bus.ioctl_dout};

  dl_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EntryW)
  ) u_fifo (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .wdata     (push_entry),
    .head      (fifo_head),
    .head_next (fifo_head_next),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    count_nxt = fifo_count;
    if (push_ok && !pop)      count_nxt = fifo_count + FifoCntW'(1);
    else if (!push_ok && pop) count_nxt = fifo_count - FifoCntW'(1);
  end

  // Entry the drain registers take on this edge. With one entry left, a byte pushed on
  // the ack edge is not in FIFO memory yet, so it is taken straight from the input.
  always_comb begin
    drain_load = 1'b0;
    load_entry = fifo_head;
    if (drain_q == DrnIdle && !fifo_empty) begin
      drain_load = 1'b1;
    end else if (pop && fifo_count > FifoCntW'(1)) begin
      drain_load = 1'b1;
      load_entry = fifo_head_next;
    end else if (pop && push_ok) begin
      drain_load = 1'b1;
      load_entry = push_entry;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      drain_q      <= DrnIdle;
      sdram_addr_q <= '0;
      sdram_din_q  <= '0;
      sdram_wr_q   <= 1'b0;
    end else if (drain_load) begin
      drain_q      <= DrnWr;
      sdram_addr_q <= SDRAM_ADDR_W'(load_entry[EntryW-1:8]);
      sdram_din_q  <= load_entry[7:0];
      sdram_wr_q   <= 1'b1;
    end else if (pop) begin
      drain_q      <= DrnIdle;
      sdram_wr_q   <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      game_mode_q <= '0;
      overflow_q  <= 1'b0;
      wait_q      <= 1'b0;
    end else begin
      if (dl_bus.ioctl_wr && dl_bus.ioctl_index == MODE_INDEX) game_mode_q <= dl_bus.ioctl_dout[4:0];
      if (push && !push_ok) overflow_q <= 1'b1;
      wait_q <= (count_nxt >= FifoCntW'(FIFO_DEPTH - 1));
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      seq_q        <= SeqIdle;
      hold_cnt_q   <= '0;
      core_reset_q <= 1'b1;
      rom_loaded_q <= 1'b0;
    end else begin
      case (seq_q)
        SeqIdle: begin
          if (rom_dl) begin
            seq_q        <= SeqLoad;
            rom_loaded_q <= 1'b1;
          end
        end
        SeqLoad: begin
          if (!rom_dl && fifo_empty && drain_q == DrnIdle) begin
            seq_q      <= SeqHold;
            hold_cnt_q <= HoldCntW'(HOLD_CYCLES);
          end
        end
        SeqHold: begin
          if (rom_dl) begin
            seq_q        <= SeqLoad;
            rom_loaded_q <= 1'b1;
          end else if (hold_cnt_q == '0) begin
            seq_q        <= SeqRun;
            core_reset_q <= 1'b0;
          end else begin
            hold_cnt_q <= hold_cnt_q - HoldCntW'(1);
          end
        end
        SeqRun: begin
          if (rom_dl) begin
            seq_q        <= SeqLoad;
            core_reset_q <= 1'b1;
            rom_loaded_q <= 1'b1;
          end
        end
        default: seq_q <= SeqIdle;
      endcase
    end
  end

  assign dl_bus.ioctl_wait = wait_q;
  assign dl_bus.sdram_addr = sdram_addr_q;
  assign dl_bus.sdram_din  = sdram_din_q;
  assign dl_bus.sdram_wr   = sdram_wr_q;
  assign game_mode         = game_mode_q;
  assign core_reset        = core_reset_q;
  assign rom_loaded        = rom_loaded_q;
  assign fifo_overflow     = overflow_q;

endmodule

// File: tb/tb_rom_download_sequencer.sv
// Directed + randomized bench for rom_download_sequencer; an SDRAM responder checks every
// write against a queue of bytes the bench expects to reach SDRAM, in order.
module tb_rom_download_sequencer;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b1;
  logic [4:0] game_mode;
  logic       core_reset, rom_loaded, fifo_overflow;

  int checks = 0;
  int errors = 0;
  int wr_done = 0;
  bit ack_en = 1'b0;
  bit rand_lat = 1'b0;
  int ack_lat = 3;
  logic [32:0] exp_q [$];

  rom_download_sequencer_if #(.ADDR_W(24), .SDRAM_ADDR_W(25)) bus ();

  rom_download_sequencer #(
    .ADDR_W       (24),
    .SDRAM_ADDR_W (25),
    .FIFO_DEPTH   (4),
    .HOLD_CYCLES  (255),
    .BRAM_INDEX   (8'd0),
    .MODE_INDEX   (8'd1),
    .SDRAM_INDEX  (8'd2)
  ) dut (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .dl_bus        (bus),
    .game_mode     (game_mode),
    .core_reset    (core_reset),
    .rom_loaded    (rom_loaded),
    .fifo_overflow (fifo_overflow)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = 8'd0;
  endtask

  task automatic do_reset();
    ack_en   = 1'b0;
    rand_lat = 1'b0;
    idle_inputs();
    reset_n  = 1'b0;
    exp_q.delete();
    wr_done  = 0;
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic drive_byte(input logic [23:0] a, input logic [7:0] d, input bit rec);
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = a;
    bus.ioctl_dout = d;
    if (rec) exp_q.push_back({1'b0, a, d});
    @(negedge clk_sys);
    bus.ioctl_wr = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int guard = 0;
    while (bus.ioctl_wait && guard < 200) begin
      @(negedge clk_sys);
      guard++;
    end
    check(tag, 64'(guard < 200), 64'd1);
  endtask

  task automatic wait_drain(input string tag);
    int guard = 0;
    while ((exp_q.size() != 0 || bus.sdram_wr) && guard < 500) begin
      @(negedge clk_sys);
      guard++;
    end
    check(tag, 64'(guard < 500), 64'd1);
  endtask

  // SDRAM model: accepts the presented write, checks it, acks after the chosen latency.
  initial begin : sdram_model
    logic [32:0] got, want;
    int lat;
    bus.sdram_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (ack_en && bus.sdram_wr) begin
        got = {bus.sdram_addr, bus.sdram_din};
        check("wr_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          want = exp_q.pop_front();
          check("wr_entry", 64'(got), 64'(want));
        end
        lat = rand_lat ? int'($urandom_range(4, 1)) : ack_lat;
        repeat (lat - 1) @(negedge clk_sys);
        if (ack_en) begin
          check("wr_stable", 64'({bus.sdram_wr, bus.sdram_addr, bus.sdram_din}), 64'({1'b1, got}));
          bus.sdram_ack = 1'b1;
          wr_done++;
          @(negedge clk_sys);
          bus.sdram_ack = 1'b0;
        end
      end
    end
  end

  initial begin : stimulus
    logic [23:0] base;
    logic [7:0]  d;
    logic [23:0] first_a;
    logic [7:0]  first_d;
    int n;

    // 1: reset, no download
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      check("reset_idle",
            64'({bus.ioctl_wait, bus.sdram_wr, bus.sdram_addr, bus.sdram_din, game_mode,
                 core_reset, rom_loaded, fifo_overflow}),
            64'({1'b0, 1'b0, 25'd0, 8'd0, 5'd0, 1'b1, 1'b0, 1'b0}));
      @(negedge clk_sys);
    end

    // 2: mode latch
    bus.ioctl_download = 1'b1;
    bus.ioctl_index    = 8'd1;
    drive_byte(24'd0, 8'hE7, 1'b0);
    check("mode_e7", 64'(game_mode), 64'h07);
    check("mode_core_reset", 64'(core_reset), 64'd1);
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      drive_byte(24'($urandom), d, 1'b0);
      check("mode_rand", 64'(game_mode), 64'(d[4:0]));
    end
    bus.ioctl_download = 1'b0;
    d = 8'($urandom);
    drive_byte(24'd0, d, 1'b0);
    check("mode_no_dl", 64'(game_mode), 64'(d[4:0]));
    repeat (10) @(negedge clk_sys);
    check("mode_stays_idle", 64'({core_reset, rom_loaded, bus.sdram_wr}), 64'({1'b1, 1'b0, 1'b0}));

    // 3: 16-byte burst, ack 3 cycles after each write
    do_reset();
    ack_lat = 3;
    base = 24'($urandom);
    bus.ioctl_download = 1'b1;
    bus.ioctl_index    = 8'd2;
    for (int i = 0; i < 2; i++) drive_byte(base + 24'(i), 8'($urandom), 1'b1);
    check("wait_at_2", 64'(bus.ioctl_wait), 64'd0);
    check("rom_loaded_set", 64'(rom_loaded), 64'd1);
    drive_byte(base + 24'd2, 8'($urandom), 1'b1);
    check("wait_at_3", 64'(bus.ioctl_wait), 64'd1);
    ack_en = 1'b1;
    for (int i = 3; i < 16; i++) begin
      wait_ready("burst_wait_bound");
      drive_byte(base + 24'(i), 8'($urandom), 1'b1);
    end
    bus.ioctl_download = 1'b0;
    wait_drain("burst_drain");
    check("burst_count", 64'(wr_done), 64'd16);
    check("burst_no_ovf", 64'(fifo_overflow), 64'd0);
    check("burst_wait_low", 64'(bus.ioctl_wait), 64'd0);

    // 3b: random bytes, gaps and ack latency
    rand_lat = 1'b1;
    wr_done  = 0;
    bus.ioctl_download = 1'b1;
    bus.ioctl_index    = 8'd2;
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(2, 0)) @(negedge clk_sys);
      wait_ready("rand_wait_bound");
      drive_byte(24'($urandom), 8'($urandom), 1'b1);
      if (i == 0) check("rand_core_reset", 64'(core_reset), 64'd1);
    end
    bus.ioctl_download = 1'b0;
    wait_drain("rand_drain");
    check("rand_count", 64'(wr_done), 64'd24);
    check("rand_no_ovf", 64'(fifo_overflow), 64'd0);

    // 4: wait ignored, no acks -> first four bytes kept, rest dropped
    do_reset();
    bus.ioctl_download = 1'b1;
    bus.ioctl_index    = 8'd2;
    base    = 24'($urandom);
    first_d = 8'($urandom);
    first_a = base;
    drive_byte(first_a, first_d, 1'b1);
    for (int i = 1; i < 16; i++) drive_byte(base + 24'(i), 8'($urandom), i < 4);
    check("ovf_flag", 64'(fifo_overflow), 64'd1);
    check("ovf_wait", 64'(bus.ioctl_wait), 64'd1);
    check("ovf_head", 64'({bus.sdram_wr, bus.sdram_addr, bus.sdram_din}),
          64'({1'b1, 1'b0, first_a, first_d}));
    bus.ioctl_download = 1'b0;
    ack_lat = 1;
    ack_en  = 1'b1;
    wait_drain("ovf_drain");
    check("ovf_count", 64'(wr_done), 64'd4);
    check("ovf_sticky", 64'(fifo_overflow), 64'd1);

    // 5: hold timing
    do_reset();
    ack_lat = 3;
    ack_en  = 1'b1;
    bus.ioctl_download = 1'b1;
    bus.ioctl_index    = 8'd2;
    base = 24'($urandom);
    for (int i = 0; i < 3; i++) drive_byte(base + 24'(i), 8'($urandom), 1'b1);
    wait_drain("hold_drain");
    bus.ioctl_download = 1'b0;
    n = 0;
    while (core_reset && n < 1000) begin
      @(negedge clk_sys);
      n++;
    end
    check("hold_release", 64'(n), 64'd257);
    check("hold_rom_loaded", 64'(rom_loaded), 64'd1);

    // 6: BRAM download from RUN, then async reset mid write
    bus.ioctl_index    = 8'd0;
    bus.ioctl_download = 1'b1;
    @(negedge clk_sys);
    check("run_to_load", 64'(core_reset), 64'd1);
    ack_en = 1'b0;
    bus.ioctl_index = 8'd2;
    drive_byte(24'($urandom), 8'($urandom), 1'b0);
    @(negedge clk_sys);
    check("mid_wr_active", 64'(bus.sdram_wr), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_clear",
          64'({bus.sdram_wr, bus.ioctl_wait, core_reset, rom_loaded, fifo_overflow, game_mode}),
          64'({1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0}));
    @(negedge clk_sys);
    idle_inputs();
    reset_n = 1'b1;
    repeat (20) @(negedge clk_sys);
    check("after_reset_idle", 64'({bus.sdram_wr, core_reset, rom_loaded}), 64'({1'b0, 1'b1, 1'b0}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
